// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI transmit path.
package midi_pkg;
    localparam logic [7:0] NOTE_OFF = 8'h80;
    localparam logic [7:0] NOTE_ON  = 8'h90;
    localparam logic [7:0] CTRL     = 8'hB0;
    localparam logic [7:0] PROG     = 8'hC0;
    localparam logic [7:0] SYS_BASE = 8'hF0;
    localparam logic [7:0] RT_BASE  = 8'hF8;

    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATUS,
        ST_DATA1,
        ST_DATA2,
        ST_DONE
    } tx_state_t;
endpackage

// File: rtl/midi_uart_tx.sv
// Single-byte 8N1 serializer; takes the next byte in the cycle its stop bit ends.
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       tx_out
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_idx;
    logic [8:0]    r_shift;
    logic          r_out;

    logic w_bit_end;
    logic w_stop_end;

    assign w_bit_end  = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_stop_end = r_active && w_bit_end && (r_idx == 4'(FRAME_BITS - 1));
    assign byte_ready = !r_active || w_stop_end;
    assign tx_out     = r_out;

    // r_shift holds the not-yet-sent data bits with the stop bit above them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '1;
            r_out    <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= {1'b1, byte_data};
            r_out    <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_idx == 4'(FRAME_BITS - 1)) begin
                    r_active <= 1'b0;
                    r_out    <= 1'b1;
                end else begin
                    r_idx   <= r_idx + 4'd1;
                    r_out   <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/midi_tx.sv
// MIDI message transmitter: handshake, byte sequencing and running-status compression.
module midi_tx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 31_250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] status,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [1:0] msg_len,
    output logic       midi_out,
    output logic       busy,
    output logic       tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    tx_state_t  r_state;
    logic       r_msg_ready;
    logic       r_busy;
    logic       r_tx_done;
    logic [7:0] r_last_status;
    logic [7:0] r_d1;
    logic [7:0] r_d2;
    logic [1:0] r_len;

    logic       w_accept;
    logic [1:0] w_len;
    logic       w_is_chan;
    logic       w_is_rt;
    logic       w_skip;
    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_uart_ready;

    assign w_accept  = msg_valid && r_msg_ready;
    assign w_len     = (msg_len == 2'd0) ? 2'd1 : msg_len;
    assign w_is_chan = (status < SYS_BASE);
    assign w_is_rt   = (status >= RT_BASE);
    assign w_skip    = (RUNNING_STATUS != 0) && w_is_chan && (status == r_last_status);

    assign msg_ready = r_msg_ready;
    assign busy      = r_busy;
    assign tx_done   = r_tx_done;

    // The first byte is handed to the serializer in the accept cycle so the
    // start bit appears on the very next cycle.
    always_comb begin
        w_byte_valid = 1'b0;
        w_byte       = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_skip) begin
                    w_byte_valid = 1'b1;
                    w_byte       = status;
                end else if (w_accept && w_len != 2'd1) begin
                    w_byte_valid = 1'b1;
                    w_byte       = data1 & 8'h7F;
                end
            end
            ST_STATUS: begin
                w_byte_valid = w_uart_ready && (r_len != 2'd1);
                w_byte       = r_d1;
            end
            ST_DATA1: begin
                w_byte_valid = w_uart_ready && (r_len == 2'd3);
                w_byte       = r_d2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_msg_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_tx_done     <= 1'b0;
            r_last_status <= 8'h00;
            r_d1          <= 8'h00;
            r_d2          <= 8'h00;
            r_len         <= 2'd1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_msg_ready <= 1'b0;
                        r_d1        <= data1 & 8'h7F;
                        r_d2        <= data2 & 8'h7F;
                        r_len       <= w_len;
                        if (w_is_chan) begin
                            if (!w_skip) r_last_status <= status;
                        end else if (!w_is_rt) begin
                            r_last_status <= 8'h00;
                        end
                        if (!w_skip) begin
                            r_state <= ST_STATUS;
                            r_busy  <= 1'b1;
                        end else if (w_len != 2'd1) begin
                            r_state <= ST_DATA1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state   <= ST_DONE;
                            r_tx_done <= 1'b1;
                        end
                    end
                end
                ST_STATUS: begin
                    if (w_uart_ready) begin
                        if (r_len != 2'd1) begin
                            r_state <= ST_DATA1;
                        end else begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_tx_done <= 1'b1;
                        end
                    end
                end
                ST_DATA1: begin
                    if (w_uart_ready) begin
                        if (r_len == 2'd3) begin
                            r_state <= ST_DATA2;
                        end else begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_tx_done <= 1'b1;
                        end
                    end
                end
                ST_DATA2: begin
                    if (w_uart_ready) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_tx_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_tx_done   <= 1'b0;
                    r_msg_ready <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    midi_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (w_byte_valid),
        .byte_ready (w_uart_ready),
        .byte_data  (w_byte),
        .tx_out     (midi_out)
    );
endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: table of messages, line decoder feeding a byte scoreboard.
module tb_midi_tx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, msg_valid, msg_valid1;
    logic [7:0] status, data1, data2;
    logic [1:0] msg_len;
    logic       msg_ready, midi_out, busy, tx_done;
    logic       msg_ready1, midi_out1, busy1, tx_done1;

    midi_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .RUNNING_STATUS(1)) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .status(status), .data1(data1), .data2(data2), .msg_len(msg_len),
        .midi_out(midi_out), .busy(busy), .tx_done(tx_done)
    );

    midi_tx #(.CLK_FREQ(1_600_000), .BAUD(100_000), .RUNNING_STATUS(0)) dut1 (
        .clk(clk), .rst(rst), .msg_valid(msg_valid1), .msg_ready(msg_ready1),
        .status(status), .data1(data1), .data2(data2), .msg_len(msg_len),
        .midi_out(midi_out1), .busy(busy1), .tx_done(tx_done1)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] st, d1, d2;
        logic [1:0] len;
        int         n;
        logic [7:0] e0, e1, e2;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line decoder: samples mid-bit, compares each received byte with the scoreboard.
    int         mon_cnt, mon_k;
    logic       mon_act = 1'b0;
    logic [7:0] mon_byte, mon_exp;
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (rst !== 1'b1) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (midi_out === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                mon_k = mon_cnt / CPB;
                if (mon_k == 0) begin
                    check("start bit", {31'd0, midi_out}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = midi_out;
                end else begin
                    check("stop bit", {31'd0, midi_out}, 32'd1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected byte: got %0h expected none", mon_byte);
                    end else begin
                        mon_exp = sb.pop_front();
                        check("rx byte", {24'd0, mon_byte}, {24'd0, mon_exp});
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (msg_ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (msg_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready timeout: got 0 expected 1");
        end
    endtask

    // Called at the first negedge after the accept edge.
    task automatic wait_done(input string nm, input int n);
        int c = 0;
        check({nm, " busy"}, {31'd0, busy}, (n > 0) ? 32'd1 : 32'd0);
        check({nm, " line"}, {31'd0, midi_out}, (n > 0) ? 32'd0 : 32'd1);
        while (tx_done !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({nm, " duration"}, c, n * 10 * CPB);
        check({nm, " busy@done"}, {31'd0, busy}, 32'd0);
        check({nm, " ready@done"}, {31'd0, msg_ready}, 32'd0);
        @(negedge clk);
        check({nm, " ready after"}, {31'd0, msg_ready}, 32'd1);
        check({nm, " done width"}, {31'd0, tx_done}, 32'd0);
        check({nm, " bytes left"}, sb.size(), 32'd0);
    endtask

    task automatic send(input string nm, input vec_t v);
        int d0;
        wait_ready();
        status    = v.st;
        data1     = v.d1;
        data2     = v.d2;
        msg_len   = v.len;
        msg_valid = 1'b1;
        if (v.n > 0) sb.push_back(v.e0);
        if (v.n > 1) sb.push_back(v.e1);
        if (v.n > 2) sb.push_back(v.e2);
        d0 = done_cnt;
        @(posedge clk);
        #1 msg_valid = 1'b0;
        @(negedge clk);
        wait_done(nm, v.n);
        check({nm, " pulses"}, done_cnt - d0, 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tr, c, d0;
        logic prev;
        vec_t v;
        rst = 1'b0; msg_valid = 1'b0; msg_valid1 = 1'b0;
        status = 8'h00; data1 = 8'h00; data2 = 8'h00; msg_len = 2'd0;

        vecs[0]  = '{8'h90, 8'h3C, 8'h64, 2'd3, 3, 8'h90, 8'h3C, 8'h64};
        vecs[1]  = '{8'h90, 8'h40, 8'h00, 2'd3, 2, 8'h40, 8'h00, 8'h00};
        vecs[2]  = '{8'hF8, 8'h11, 8'h22, 2'd1, 1, 8'hF8, 8'h00, 8'h00};
        vecs[3]  = '{8'h90, 8'h3C, 8'h00, 2'd3, 2, 8'h3C, 8'h00, 8'h00};
        vecs[4]  = '{8'hF0, 8'h00, 8'h00, 2'd1, 1, 8'hF0, 8'h00, 8'h00};
        vecs[5]  = '{8'h90, 8'h3C, 8'h00, 2'd3, 3, 8'h90, 8'h3C, 8'h00};
        vecs[6]  = '{8'h90, 8'h3C, 8'h00, 2'd1, 0, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{8'hC0, 8'h05, 8'h00, 2'd2, 2, 8'hC0, 8'h05, 8'h00};
        vecs[8]  = '{8'hC0, 8'h85, 8'h00, 2'd2, 1, 8'h05, 8'h00, 8'h00};
        vecs[9]  = '{8'hB0, 8'h07, 8'h7F, 2'd0, 1, 8'hB0, 8'h00, 8'h00};
        vecs[10] = '{8'h80, 8'h3C, 8'h40, 2'd3, 3, 8'h80, 8'h3C, 8'h40};
        vecs[11] = '{8'h90, 8'hC5, 8'hFF, 2'd3, 3, 8'h90, 8'h45, 8'h7F};

        // Reset state and quiet idle line
        repeat (3) @(negedge clk);
        check("rst line", {31'd0, midi_out}, 32'd1);
        check("rst ready", {31'd0, msg_ready}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, tx_done}, 32'd0);
        rst = 1'b1;
        tr = 0;
        prev = midi_out;
        repeat (100) begin
            @(negedge clk);
            if (midi_out !== prev || midi_out !== 1'b1 || msg_ready !== 1'b1 || busy !== 1'b0)
                tr++;
            prev = midi_out;
        end
        check("idle 100 cycles", tr, 32'd0);

        for (int i = 0; i < 12; i++) send($sformatf("vec%0d", i), vecs[i]);

        // Valid held high with changing data while a message is in flight
        wait_ready();
        d0 = done_cnt;
        status = 8'hE0; data1 = 8'h01; data2 = 8'h02; msg_len = 2'd3; msg_valid = 1'b1;
        sb.push_back(8'hE0); sb.push_back(8'h01); sb.push_back(8'h02);
        @(posedge clk);
        @(negedge clk);
        c = 0;
        while (tx_done !== 1'b1 && c < 3000) begin
            status = 8'h80 + 8'($urandom_range(0, 8'h6F));
            data1  = 8'($urandom);
            data2  = 8'($urandom);
            @(negedge clk);
            c++;
        end
        check("abuse1 duration", c, 32'd480);
        status = 8'hE0; data1 = 8'h03; data2 = 8'h04;
        check("abuse ready@done", {31'd0, msg_ready}, 32'd0);
        sb.push_back(8'h03); sb.push_back(8'h04);
        @(negedge clk);
        check("abuse ready", {31'd0, msg_ready}, 32'd1);
        @(posedge clk);
        #1 msg_valid = 1'b0;
        @(negedge clk);
        wait_done("abuse2", 2);
        check("abuse pulses", done_cnt - d0, 32'd2);

        // Reset in data bit 4 of the first data byte
        wait_ready();
        status = 8'h90; data1 = 8'h45; data2 = 8'h66; msg_len = 2'd3; msg_valid = 1'b1;
        sb.push_back(8'h90); sb.push_back(8'h45); sb.push_back(8'h66);
        @(posedge clk);
        #1 msg_valid = 1'b0;
        @(negedge clk);
        repeat (245) @(negedge clk);
        check("pre-reset bit4", {31'd0, midi_out}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid reset line", {31'd0, midi_out}, 32'd1);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset ready", {31'd0, msg_ready}, 32'd1);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        v = '{8'h90, 8'h3C, 8'h64, 2'd3, 3, 8'h90, 8'h3C, 8'h64};
        send("after reset", v);

        // Running status disabled: repeated status is always sent
        for (int i = 0; i < 2; i++) begin
            c = 0;
            while (msg_ready1 !== 1'b1 && c < 3000) begin
                @(negedge clk);
                c++;
            end
            status = 8'h90; data1 = 8'h3C + 8'(i); data2 = 8'h64; msg_len = 2'd3;
            msg_valid1 = 1'b1;
            @(posedge clk);
            #1 msg_valid1 = 1'b0;
            @(negedge clk);
            c = 0;
            while (tx_done1 !== 1'b1 && c < 3000) begin
                @(negedge clk);
                c++;
            end
            check($sformatf("rs0 msg%0d duration", i), c, 32'd480);
            @(negedge clk);
        end
        check("rs0 dut idle line", {31'd0, midi_out}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/midi_tx.md
# midi_tx

MIDI 1.0 serial transmitter: the outbound counterpart of the synth's `midi_in` receive path. It accepts complete 1–3 byte MIDI messages over a valid/ready handshake and serializes them onto `midi_out` as 31 250-baud 8N1 UART frames. It optionally applies running-status compression. It sits beside the synth top level, so a sequencer or arpeggiator can drive external gear or loop back into `midi_in`.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 31_250: line bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, an integer ≥ 2.
- `RUNNING_STATUS`, 1: 1 = omit a repeated channel status byte; 0 = always send the status byte.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `msg_valid` input 1: message present on `status`/`data1`/`data2`/`msg_len`.
- `msg_ready` output 1: transmitter can accept a message.
- `status` input 8: status byte, with bit 7 set.
- `data1` input 8: first data byte (bit 7 ignored, sent as 0).
- `data2` input 8: second data byte (bit 7 ignored, sent as 0).
- `msg_len` input 2: total bytes including status. 1–3; a value of 0 is treated as 1.
- `midi_out` output 1: serial line, idle high.
- `busy` output 1: a message is being serialized.
- `tx_done` output 1: one-cycle pulse when the last stop bit of a message completes.

## Operation
- Accept occurs on `msg_valid && msg_ready`. The block captures all inputs, and `msg_ready` deasserts the next cycle. Inputs are don't-care while `msg_ready` is 0.
- Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Top FSM states: IDLE → STATUS → DATA1 → DATA2 → DONE → IDLE.
  - Byte states are skipped according to `msg_len`.
  - STATUS is skipped under running status.
- Running status uses a `last_status` register, reset to 0x00.
  - Status 0x80–0xEF: if `RUNNING_STATUS` is set and `status == last_status`, STATUS is skipped. Otherwise the byte is sent and `last_status` is updated.
  - Status 0xF0–0xF7: always sent; clears `last_status` to 0x00.
  - Status 0xF8–0xFF (realtime): always sent; `last_status` is unchanged.
- A running-status message with `msg_len` = 1 sends no bytes. It still completes through DONE with a `tx_done` pulse.
- Reset values: `midi_out` = 1, `msg_ready` = 1, `busy` = 0, `tx_done` = 0, FSM in IDLE, bit counters 0, `last_status` = 0x00.
- Reset mid-frame aborts the current frame immediately. The line is high while `rst` is low.

## Timing
- Accept at cycle T: `busy` = 1 and `midi_out` = 0 (start bit) from T+1.
- Consecutive bytes of one message are back-to-back: the next start bit begins the cycle after the previous stop bit ends. There is no idle gap.
- Message duration: bytes_sent × 10 × `CLKS_PER_BIT` cycles.
- `tx_done` is high in the cycle after the final stop bit ends. In that same cycle `busy` = 0, and `msg_ready` = 1 from the following cycle.
- Minimum line idle between messages: 2 cycles (DONE + accept), then the next start bit.
- An empty send (running status, `msg_len` = 1): `tx_done` at T+1, with `midi_out` held high throughout.
- `msg_valid` while `msg_ready` = 0 has no effect. There is no queueing.

## Structure
- Shared package `midi_pkg` holds:
  - Status class constants: NOTE_OFF 0x80, NOTE_ON 0x90, CTRL 0xB0, PROG 0xC0, SYS_BASE 0xF0, RT_BASE 0xF8.
  - The frame length constant (10 bits).
  - The top FSM state enum.
- Sub-module `midi_uart_tx` is a single-byte 8N1 serializer with `byte_valid`/`byte_ready`, a `CLKS_PER_BIT` counter and a bit index. It must accept a new byte in the cycle its stop bit ends, so back-to-back frames have no gap.
- `midi_tx` owns the handshake, message sequencing and running-status logic.

## Test plan
Benches use `CLK_FREQ` = 1_600_000 and `BAUD` = 100_000, so `CLKS_PER_BIT` = 16.
1. Reset: hold `rst` low, then release → `midi_out` = 1, `msg_ready` = 1, `busy` = 0, with no transitions for 100 cycles.
2. Note-on: accept 0x90/0x3C/0x64, `msg_len` 3 → line carries frames 0x90, 0x3C, 0x64 LSB-first, 480 cycles total. `tx_done` pulses once at T+481.
3. Running status: repeat 0x90/0x40/0x00 after test 2 → only 0x40, 0x00 are sent (320 cycles). With `RUNNING_STATUS` = 0 → 3 bytes are sent.
4. Realtime and sysex: after a 0x90 message, send 0xF8 (`msg_len` 1) then 0x90/0x3C/0x00 → the second message omits its status byte. Send 0xF0 then 0x90 → the 0x90 status byte is sent.
5. Handshake abuse: hold `msg_valid` high with changing data during a send → only the first message is transmitted. The next is accepted only when `msg_ready` = 1.
6. Reset mid-frame: assert `rst` in bit 4 of a data byte → `midi_out` is high the same cycle. After release, a 0x90 message transmits its status byte.
